// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and parity helper for the PS/2 keyboard-side transmitter.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK       = 8'hF0;
  localparam logic [7:0] SC_LSHIFT      = 8'h12;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    SEND   = 2'd2,
    GAP    = 2'd3
  } ps2_state_e;

  // Parity bit that makes the count of ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ascii_to_scancode.sv
// ASCII to PS/2 set-2 make code lookup; upper-case letters reuse the lower-case code with shift set.
module ascii_to_scancode
  import ps2_pkg::*;
(
  input  logic [7:0] in_ascii,
  output logic       map_valid,
  output logic       map_shift,
  output logic [7:0] map_code
);

  logic [7:0] lc;

  always_comb begin
    lc        = in_ascii;
    map_valid = 1'b1;
    map_shift = 1'b0;
    map_code  = 8'h00;
    if (in_ascii >= 8'h41 && in_ascii <= 8'h5A) begin
      lc        = in_ascii | 8'h20;
      map_shift = 1'b1;
    end
    case (lc)
      "a": map_code = 8'h1C;
      "b": map_code = 8'h32;
      "c": map_code = 8'h21;
      "d": map_code = 8'h23;
      "e": map_code = 8'h24;
      "f": map_code = 8'h2B;
      "g": map_code = 8'h34;
      "h": map_code = 8'h33;
      "i": map_code = 8'h43;
      "j": map_code = 8'h3B;
      "k": map_code = 8'h42;
      "l": map_code = 8'h4B;
      "m": map_code = 8'h3A;
      "n": map_code = 8'h31;
      "o": map_code = 8'h44;
      "p": map_code = 8'h4D;
      "q": map_code = 8'h15;
      "r": map_code = 8'h2D;
      "s": map_code = 8'h1B;
      "t": map_code = 8'h2C;
      "u": map_code = 8'h3C;
      "v": map_code = 8'h2A;
      "w": map_code = 8'h1D;
      "x": map_code = 8'h22;
      "y": map_code = 8'h35;
      "z": map_code = 8'h1A;
      "0": map_code = 8'h45;
      "1": map_code = 8'h16;
      "2": map_code = 8'h1E;
      "3": map_code = 8'h26;
      "4": map_code = 8'h25;
      "5": map_code = 8'h2E;
      "6": map_code = 8'h36;
      "7": map_code = 8'h3D;
      "8": map_code = 8'h3E;
      "9": map_code = 8'h46;
      " ": map_code = 8'h29;
      8'h0A: map_code = 8'h5A;
      8'h08: map_code = 8'h66;
      default: begin
        map_valid = 1'b0;
        map_shift = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ascii_to_ps2_tx.sv
// Typed-text PS/2 source: character FIFO, make/break sequencer and 11-bit frame serializer.
module ascii_to_ps2_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_ascii,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       unmapped
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] BIT_LAST  = DW'(2 * CLK_DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  // ---------------- character FIFO ----------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  rd_data_q;
  logic        full, empty, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = in_valid && !full;

  // Head entry is re-read every cycle, so it is ready by the LOOKUP that pops it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_ascii;
    rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ---------------- mapping ----------------
  logic       map_valid, map_shift;
  logic [7:0] map_code;

  ascii_to_scancode u_map (
    .in_ascii (rd_data_q),
    .map_valid(map_valid),
    .map_shift(map_shift),
    .map_code (map_code)
  );

  function automatic logic [7:0] seq_byte(input logic shift, input logic [7:0] code,
                                          input logic [2:0] idx);
    logic [7:0] b;
    if (shift) begin
      case (idx)
        3'd0:    b = SC_LSHIFT;
        3'd1:    b = code;
        3'd2:    b = SC_BREAK;
        3'd3:    b = code;
        3'd4:    b = SC_BREAK;
        default: b = SC_LSHIFT;
      endcase
    end else begin
      case (idx)
        3'd0:    b = code;
        3'd1:    b = SC_BREAK;
        default: b = code;
      endcase
    end
    return b;
  endfunction

  // ---------------- sequencer + serializer ----------------
  ps2_state_e    state_q, state_d;
  logic          shift_q, shift_d;
  logic [7:0]    code_q, code_d;
  logic [2:0]    idx_q, idx_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic          ps2_clk_q, ps2_clk_d;
  logic          ps2_data_q, ps2_data_d;
  logic          unmapped_q, unmapped_d;
  logic          load;
  logic [7:0]    load_byte;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    code_d     = code_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    bit_d      = bit_q;
    div_d      = div_q;
    ps2_clk_d  = ps2_clk_q;
    ps2_data_d = ps2_data_q;
    unmapped_d = 1'b0;
    pop        = 1'b0;
    load       = 1'b0;
    load_byte  = 8'h00;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = LOOKUP;
      end
      LOOKUP: begin
        pop = 1'b1;
        if (!map_valid) begin
          unmapped_d = 1'b1;
          state_d    = IDLE;
        end else begin
          shift_d   = map_shift;
          code_d    = map_code;
          idx_d     = 3'd0;
          load      = 1'b1;
          load_byte = seq_byte(map_shift, map_code, 3'd0);
        end
      end
      SEND: begin
        div_d = div_q + 1'b1;
        if (div_q == HALF_LAST) ps2_clk_d = 1'b0;
        if (div_q == BIT_LAST) begin
          div_d     = '0;
          ps2_clk_d = 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d = GAP;
          end else begin
            bit_d      = bit_q + 4'd1;
            ps2_data_d = frame_q[0];
            frame_d    = {1'b1, frame_q[9:1]};
          end
        end
      end
      GAP: begin
        div_d = div_q + 1'b1;
        if (div_q == BIT_LAST) begin
          div_d = '0;
          if ((shift_q && idx_q == 3'd5) || (!shift_q && idx_q == 3'd2)) begin
            state_d = IDLE;
          end else begin
            idx_d     = idx_q + 3'd1;
            load      = 1'b1;
            load_byte = seq_byte(shift_q, code_q, idx_q + 3'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Start bit goes out immediately; frame_d holds data, parity and stop, LSB first.
    if (load) begin
      state_d    = SEND;
      frame_d    = {1'b1, odd_parity(load_byte), load_byte};
      ps2_data_d = 1'b0;
      ps2_clk_d  = 1'b1;
      bit_d      = 4'd0;
      div_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= 1'b0;
      code_q     <= 8'h00;
      idx_q      <= 3'd0;
      frame_q    <= '1;
      bit_q      <= 4'd0;
      div_q      <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      unmapped_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      code_q     <= code_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      unmapped_q <= unmapped_d;
    end
  end

  assign in_ready = !full;
  assign busy     = !empty || (state_q != IDLE);
  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign unmapped = unmapped_q;

endmodule

// File: tb/tb_ascii_to_ps2_tx.sv
// Self-checking bench: frame monitor decodes PS/2 bytes into a queue and compares against a scoreboard.
module tb_ascii_to_ps2_tx;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_ascii = 8'h00;
  logic       in_ready, ps2_clk, ps2_data, busy, unmapped;

  always #5 clk = ~clk;

  ascii_to_ps2_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ascii(in_ascii),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .busy    (busy),
    .unmapped(unmapped)
  );

  typedef struct {
    logic [7:0] ascii;
    logic       ok;
    logic       shift;
    logic [7:0] code;
  } vec_t;

  vec_t        vecs[14];
  logic [7:0]  exp_q[$];
  logic [10:0] frm_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int falls = 0;
  int unm_cycles = 0;
  int bit_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- frame monitor (samples 1 time unit after each rising edge) ----------------
  logic        prev_clk = 1'b1, prev_data = 1'b1, measuring = 1'b0;
  int          cyc = 0, high_cnt = 0;
  logic [10:0] bits = '0;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (unmapped) unm_cycles++;
    if (rst) begin
      bit_cnt   = 0;
      measuring = 1'b0;
    end else begin
      if (ps2_data !== prev_data) chk("data_changes_with_clk_high", ps2_clk, 1);
      if (measuring) begin
        if (ps2_clk && ps2_data) high_cnt++;
        else if (!ps2_data) begin
          chk("gap_both_high_ge8", (high_cnt >= 2 * CLK_DIV), 1);
          measuring = 1'b0;
        end
      end
      if (prev_clk && !ps2_clk) begin
        falls++;
        if (bit_cnt > 0) chk("fall_spacing", cyc, 2 * CLK_DIV);
        cyc = 0;
        bits[bit_cnt[3:0]] = ps2_data;
        bit_cnt++;
        if (bit_cnt == 11) begin
          chk("start_bit", bits[0], 0);
          chk("stop_bit", bits[10], 1);
          chk("parity_odd", ^bits[9:1], 1);
          frm_q.push_back(bits);
          bit_cnt   = 0;
          measuring = 1'b1;
          high_cnt  = 0;
        end
      end
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic expect_push(input logic [7:0] c);
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].ascii == c && vecs[i].ok) begin
        if (vecs[i].shift) begin
          exp_q.push_back(8'h12); exp_q.push_back(vecs[i].code);
          exp_q.push_back(8'hF0); exp_q.push_back(vecs[i].code);
          exp_q.push_back(8'hF0); exp_q.push_back(8'h12);
        end else begin
          exp_q.push_back(vecs[i].code); exp_q.push_back(8'hF0);
          exp_q.push_back(vecs[i].code);
        end
      end
    end
  endtask

  task automatic push_char(input logic [7:0] c, input bit track);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_ascii = c;
    for (t = 0; t < 5000 && !in_ready; t++) @(negedge clk);
    if (!in_ready) begin
      chk("push_accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      if (track) expect_push(c);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int t;
    for (t = 0; t < budget && busy; t++) @(negedge clk);
    chk("busy_falls", busy, 0);
  endtask

  task automatic drain(input string name);
    logic [10:0] f;
    logic [7:0]  e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (frm_q.size() == 0) begin
        chk("rx_byte_missing", 0, {24'h0, e});
      end else begin
        f = frm_q.pop_front();
        chk(name, f[8:1], e);
      end
    end
    chk("rx_extra_frames", frm_q.size(), 0);
    frm_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, f0, u0, nb;
    logic [7:0] fill[9];
    logic pdata;

    vecs[0]  = '{8'h61, 1'b1, 1'b0, 8'h1C};  // a
    vecs[1]  = '{8'h71, 1'b1, 1'b0, 8'h15};  // q
    vecs[2]  = '{8'h41, 1'b1, 1'b1, 8'h1C};  // A
    vecs[3]  = '{8'h5A, 1'b1, 1'b1, 8'h1A};  // Z
    vecs[4]  = '{8'h30, 1'b1, 1'b0, 8'h45};  // 0
    vecs[5]  = '{8'h39, 1'b1, 1'b0, 8'h46};  // 9
    vecs[6]  = '{8'h20, 1'b1, 1'b0, 8'h29};  // space
    vecs[7]  = '{8'h0A, 1'b1, 1'b0, 8'h5A};  // newline
    vecs[8]  = '{8'h08, 1'b1, 1'b0, 8'h66};  // backspace
    vecs[9]  = '{8'h7A, 1'b1, 1'b0, 8'h1A};  // z
    vecs[10] = '{8'h6D, 1'b1, 1'b0, 8'h3A};  // m
    vecs[11] = '{8'h7F, 1'b0, 1'b0, 8'h00};  // DEL
    vecs[12] = '{8'h40, 1'b0, 1'b0, 8'h00};  // @
    vecs[13] = '{8'h5B, 1'b0, 1'b0, 8'h00};  // [

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ps2_clk", ps2_clk, 1);
    chk("rst_ps2_data", ps2_data, 1);
    chk("rst_busy", busy, 0);
    chk("rst_unmapped", unmapped, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 'a': start-bit latency, exact frame for 1C, byte sequence
    push_char(8'h61, 1'b1);
    lat = 0;
    while (ps2_data && lat < 10) begin @(negedge clk); lat++; end
    chk("send_entry_latency", lat, 2);
    wait_idle(2000);
    if (frm_q.size() > 0) chk("frame_1C_bits", frm_q[0], 11'b10000111000);
    else chk("frame_1C_present", 0, 1);
    drain("a_bytes");

    // 'A': shifted sequence, frames for 12 and F0
    push_char(8'h41, 1'b1);
    wait_idle(3000);
    if (frm_q.size() > 2) begin
      chk("frame_12_bits", frm_q[0], 11'b11000100100);
      chk("frame_F0_bits", frm_q[2], 11'b11111100000);
    end else chk("frame_A_present", 0, 1);
    drain("A_bytes");

    // DEL: unmapped pulse timing, no clocking
    f0 = falls; u0 = unm_cycles;
    push_char(8'h7F, 1'b1);
    lat = 0;
    while (!unmapped && lat < 10) begin @(negedge clk); lat++; end
    chk("unmapped_latency", lat, 2);
    @(negedge clk);
    chk("unmapped_one_cycle", unmapped, 0);
    wait_idle(100);
    repeat (4) @(negedge clk);
    chk("unmapped_pulse_count", unm_cycles - u0, 1);
    chk("unmapped_no_falls", falls - f0, 0);

    // Table-driven characters
    for (int i = 0; i < 14; i++) begin
      f0 = falls; u0 = unm_cycles;
      push_char(vecs[i].ascii, 1'b1);
      wait_idle(3000);
      repeat (2) @(negedge clk);
      nb = vecs[i].ok ? (vecs[i].shift ? 6 : 3) : 0;
      chk("tbl_unmapped_pulses", unm_cycles - u0, vecs[i].ok ? 0 : 1);
      chk("tbl_fall_count", falls - f0, 11 * nb);
      drain("tbl_bytes");
    end

    // FIFO fill with the line stalled by an 'A' sequence
    fill = '{8'h61, 8'h71, 8'h30, 8'h39, 8'h20, 8'h7A, 8'h6D, 8'h5A, 8'h0A};
    push_char(8'h41, 1'b1);
    lat = 0;
    while (ps2_data && lat < 10) begin @(negedge clk); lat++; end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_ascii = fill[i];
      chk("fill_in_ready", in_ready, 1);
      expect_push(fill[i]);
      @(negedge clk);
    end
    in_ascii = fill[8];
    chk("full_in_ready_low", in_ready, 0);
    lat = 0;
    pdata = ps2_data;
    while (!in_ready && lat < 2000) begin
      pdata = ps2_data;
      @(negedge clk);
      lat++;
    end
    chk("ninth_waits_for_pop", in_ready, 1);
    chk("ninth_after_pop_start_bit", ps2_data, 0);
    chk("ninth_after_pop_prev_high", pdata, 1);
    expect_push(fill[8]);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(12000);
    drain("fifo_order_bytes");

    // Reset during bit 5 of the first frame
    push_char(8'h61, 1'b0);
    push_char(8'h71, 1'b0);
    push_char(8'h30, 1'b0);
    lat = 0;
    while (bit_cnt != 5 && lat < 1000) begin @(negedge clk); lat++; end
    chk("reached_bit5", bit_cnt, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ps2_clk", ps2_clk, 1);
    chk("midrst_ps2_data", ps2_data, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst = 1'b0;
    f0 = falls;
    repeat (600) @(negedge clk);
    chk("after_rst_no_falls", falls - f0, 0);
    chk("after_rst_no_frames", frm_q.size(), 0);
    chk("after_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
